// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit TinyMIPS core: byte-wise instruction fetch, decode and
// sequencing of LB/SB/R-type/BEQ/J/ADDI, plus the ALU decoder feeding the datapath.
module mips_controller #(
  parameter logic [5:0] OP_LB    = 6'b100000,
  parameter logic [5:0] OP_SB    = 6'b101000,
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic [1:0] pcsource,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd1,
    S_FETCH2  = 4'd2,
    S_FETCH3  = 4'd3,
    S_FETCH4  = 4'd4,
    S_DECODE  = 4'd5,
    S_MEMADR  = 4'd6,
    S_LBRD    = 4'd7,
    S_LBWR    = 4'd8,
    S_SBWR    = 4'd9,
    S_RTYPEEX = 4'd10,
    S_RTYPEWR = 4'd11,
    S_BEQEX   = 4'd12,
    S_JEX     = 4'd13,
    S_ADDIEX  = 4'd14,
    S_ADDIWR  = 4'd15
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       pcwritecond;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH1;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d     = S_FETCH1;
    memread     = 1'b0;
    memwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    iord        = 1'b0;
    irwrite     = 4'b0000;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    pcsource    = 2'b00;
    aluop       = 2'b00;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    case (state_q)
      S_FETCH1: begin
        memread = 1'b1; irwrite = 4'b0001; alusrcb = 2'b01; pcwrite = 1'b1;
        state_d = S_FETCH2;
      end
      S_FETCH2: begin
        memread = 1'b1; irwrite = 4'b0010; alusrcb = 2'b01; pcwrite = 1'b1;
        state_d = S_FETCH3;
      end
      S_FETCH3: begin
        memread = 1'b1; irwrite = 4'b0100; alusrcb = 2'b01; pcwrite = 1'b1;
        state_d = S_FETCH4;
      end
      S_FETCH4: begin
        memread = 1'b1; irwrite = 4'b1000; alusrcb = 2'b01; pcwrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        // Unknown opcodes fall back to FETCH1 and behave as a NOP.
        if ((op == OP_LB) || (op == OP_SB)) state_d = S_MEMADR;
        else if (op == OP_RTYPE)            state_d = S_RTYPEEX;
        else if (op == OP_BEQ)              state_d = S_BEQEX;
        else if (op == OP_J)                state_d = S_JEX;
        else if (op == OP_ADDI)             state_d = S_ADDIEX;
        else                                state_d = S_FETCH1;
      end
      S_MEMADR: begin
        alusrca = 1'b1; alusrcb = 2'b10;
        state_d = (op == OP_LB) ? S_LBRD : S_SBWR;
      end
      S_LBRD: begin
        memread = 1'b1; iord = 1'b1;
        state_d = S_LBWR;
      end
      S_LBWR: begin
        regwrite = 1'b1; memtoreg = 1'b1;
      end
      S_SBWR: begin
        memwrite = 1'b1; iord = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1; aluop = 2'b10;
        state_d = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        regwrite = 1'b1; regdst = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1; aluop = 2'b01; pcsource = 2'b01; pcwritecond = 1'b1;
      end
      S_JEX: begin
        pcsource = 2'b10; pcwrite = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1; alusrcb = 2'b10;
        state_d = S_ADDIWR;
      end
      S_ADDIWR: begin
        regwrite = 1'b1;
      end
      default: state_d = S_FETCH1;
    endcase
  end

  // Branch takes effect in the same cycle the datapath reports zero.
  assign pcen = pcwrite | (pcwritecond & zero);

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b101;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for mips_controller: an instruction-level model predicts the state walk and the
// control word for every cycle; literal expectations pin the model at chosen points.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] irwrite, state;
  logic [2:0] alucontrol;

  mips_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .iord(iord), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .pcsource(pcsource), .pcen(pcen), .alucontrol(alucontrol),
    .state(state)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [22:0] exp_q[$];
  bit          chk_en = 1'b0;
  logic [22:0] dut_w;

  assign dut_w = {state, memread, memwrite, alusrca, alusrcb, iord, irwrite,
                  memtoreg, regdst, regwrite, pcsource, pcen, alucontrol};

  task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [22:0] mk(input logic [3:0] st, input logic mr, input logic mw,
                                     input logic asa, input logic [1:0] asb, input logic iod,
                                     input logic [3:0] irw, input logic mtr, input logic rd,
                                     input logic rw, input logic [1:0] pcs, input logic pe,
                                     input logic [2:0] ac);
    return {st, mr, mw, asa, asb, iod, irw, mtr, rd, rw, pcs, pe, ac};
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b101;
    endcase
  endfunction

  // Control word the datapath must see in a given step of an instruction.
  function automatic logic [22:0] model_word(input logic [3:0] st, input logic [5:0] f,
                                             input logic z);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << (st - 4'd1);
    case (st)
      4'd1, 4'd2, 4'd3, 4'd4:
        return mk(st, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, one_hot, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'b010);
      4'd5:  return mk(st, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b010);
      4'd6:  return mk(st, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b010);
      4'd7:  return mk(st, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b010);
      4'd8:  return mk(st, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 3'b010);
      4'd9:  return mk(st, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b010);
      4'd10: return mk(st, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, rtype_alu(f));
      4'd11: return mk(st, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 3'b010);
      4'd12: return mk(st, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b01, z,    3'b110);
      4'd13: return mk(st, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 3'b010);
      4'd14: return mk(st, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b010);
      4'd15: return mk(st, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 3'b010);
      default: return 23'h0;
    endcase
  endfunction

  // Queue the whole step list of one instruction; returns its length in cycles.
  task automatic push_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            output int n);
    logic [3:0] seq[$];
    for (int i = 1; i <= 5; i++) seq.push_back(4'(i));
    case (o)
      6'b100000: begin seq.push_back(4'd6); seq.push_back(4'd7); seq.push_back(4'd8); end
      6'b101000: begin seq.push_back(4'd6); seq.push_back(4'd9); end
      6'b000000: begin seq.push_back(4'd10); seq.push_back(4'd11); end
      6'b000100: seq.push_back(4'd12);
      6'b000010: seq.push_back(4'd13);
      6'b001000: begin seq.push_back(4'd14); seq.push_back(4'd15); end
      default: ;
    endcase
    foreach (seq[i]) exp_q.push_back(model_word(seq[i], f, z));
    n = seq.size();
  endtask

  // Called one time unit after a rising edge with the DUT in FETCH1.
  task automatic issue(input string name, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input int lat, input int pk, input logic [22:0] pw);
    int n;
    op = o; funct = f; zero = z;
    push_instr(o, f, z, n);
    check({name, "_latency"}, 23'(n), 23'(lat));
    for (int i = 0; i < n; i++) begin
      if (i == pk) begin
        #1;
        check({name, "_peek"}, dut_w, pw);
      end
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_wr_exclusive", 23'(memread & memwrite), 23'd0);
      if (exp_q.size() != 0) check("cycle_word", dut_w, exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b0; op = 6'b0; funct = 6'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_word", dut_w,
          mk(4'd1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'b010));
    reset = 1'b1;
    chk_en = 1'b1;

    issue("rtype_add", 6'b000000, 6'b100000, 1'b0, 7, 5,
          mk(4'd10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b010));
    issue("rtype_sub", 6'b000000, 6'b100010, 1'b1, 7, 6,
          mk(4'd11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 3'b010));
    issue("rtype_and", 6'b000000, 6'b100100, 1'b0, 7, 5,
          mk(4'd10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000));
    issue("rtype_or", 6'b000000, 6'b100101, 1'b0, 7, 5,
          mk(4'd10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b001));
    issue("rtype_slt", 6'b000000, 6'b101010, 1'b0, 7, 5,
          mk(4'd10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b111));
    issue("rtype_badfunct", 6'b000000, 6'b000000, 1'b0, 7, 5,
          mk(4'd10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b101));
    issue("beq_taken", 6'b000100, 6'b000000, 1'b1, 6, 5,
          mk(4'd12, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 3'b110));
    issue("beq_not_taken", 6'b000100, 6'b000000, 1'b0, 6, 5,
          mk(4'd12, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 3'b110));
    issue("lb_rd", 6'b100000, 6'b010101, 1'b1, 8, 6,
          mk(4'd7, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b010));
    issue("lb_wr", 6'b100000, 6'b000000, 1'b0, 8, 7,
          mk(4'd8, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 3'b010));
    issue("sb", 6'b101000, 6'b000000, 1'b0, 7, 6,
          mk(4'd9, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b010));
    issue("jump", 6'b000010, 6'b000000, 1'b0, 6, 5,
          mk(4'd13, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 3'b010));
    issue("addi", 6'b001000, 6'b000000, 1'b1, 7, 5,
          mk(4'd14, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b010));
    issue("illegal_op", 6'b111111, 6'b100000, 1'b0, 5, 4,
          mk(4'd5, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b010));
    issue("fetch3", 6'b001000, 6'b000000, 1'b0, 7, 2,
          mk(4'd3, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'b010));

    // Reset asserted in the middle of an R-type execute step.
    op = 6'b000000; funct = 6'b100000; zero = 1'b0;
    for (int i = 1; i <= 5; i++) exp_q.push_back(model_word(4'(i), funct, zero));
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_state", 23'(state), 23'd10);
    reset = 1'b0;
    #1;
    check("async_reset_word", dut_w,
          mk(4'd1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'b010));
    @(posedge clk);
    #1;
    check("reset_held_state", 23'(state), 23'd1);
    reset = 1'b1;
    issue("post_reset", 6'b000010, 6'b000000, 1'b0, 6, 1,
          mk(4'd2, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'b010));

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    check("queue_drained", 23'(exp_q.size()), 23'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
